// File: rtl/rfid_pkg.sv
// Shared constants for the RFID tag controller: opcodes, field positions,
// state and reply encodings, and the command-field decode helpers.
package rfid_pkg;

    typedef enum logic [2:0] {
        ST_READY        = 3'd0,
        ST_ARBITRATE    = 3'd1,
        ST_REPLY        = 3'd2,
        ST_ACKNOWLEDGED = 3'd3,
        ST_OPEN         = 3'd4
    } tag_state_t;

    typedef enum logic [2:0] {
        TX_NONE   = 3'd0,
        TX_RN16   = 3'd1,
        TX_EPC    = 3'd2,
        TX_HANDLE = 3'd3,
        TX_ERROR  = 3'd4
    } tx_type_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_QUERYREP,
        CMD_ACK,
        CMD_QUERY,
        CMD_QUERYADJ,
        CMD_REQRN,
        CMD_READ,
        CMD_WRITE,
        CMD_KILL
    } cmd_t;

    localparam int unsigned OP_SHORT_LEN = 2;
    localparam int unsigned OP_MID_LEN   = 4;
    localparam int unsigned OP_LONG_LEN  = 8;

    localparam logic [1:0] OP_QUERYREP = 2'b00;
    localparam logic [1:0] OP_ACK      = 2'b01;
    localparam logic [3:0] OP_QUERY    = 4'b1000;
    localparam logic [3:0] OP_QUERYADJ = 4'b1001;
    localparam logic [7:0] OP_REQRN    = 8'b1100_0001;
    localparam logic [7:0] OP_READ     = 8'b1100_0010;
    localparam logic [7:0] OP_WRITE    = 8'b1100_0011;
    localparam logic [7:0] OP_KILL     = 8'b1100_0100;

    localparam int unsigned QUERY_SESS_LSB = 116;
    localparam int unsigned QUERY_Q_LSB    = 111;
    localparam int unsigned QREP_SESS_LSB  = 124;
    localparam int unsigned QADJ_SESS_LSB  = 122;
    localparam int unsigned QADJ_UPDN_LSB  = 119;
    localparam int unsigned ACK_RN_LSB     = 110;
    localparam int unsigned REQRN_RN_LSB   = 104;

    localparam logic [2:0]  UPDN_INC   = 3'b110;
    localparam logic [2:0]  UPDN_DEC   = 3'b011;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [14:0] SLOT_PARK  = 15'h7FFF;

    typedef struct packed {
        cmd_t        cmd;
        logic [1:0]  session;
        logic [3:0]  q;
        logic [2:0]  updn;
        logic [15:0] rn;
    } cmd_fields_t;

    function automatic cmd_t decode_opcode(input logic [127:0] p);
        cmd_t c;
        c = CMD_NONE;
        if (p[127 -: OP_SHORT_LEN] == OP_QUERYREP)     c = CMD_QUERYREP;
        else if (p[127 -: OP_SHORT_LEN] == OP_ACK)     c = CMD_ACK;
        else if (p[127 -: OP_MID_LEN] == OP_QUERY)     c = CMD_QUERY;
        else if (p[127 -: OP_MID_LEN] == OP_QUERYADJ)  c = CMD_QUERYADJ;
        else if (p[127 -: OP_LONG_LEN] == OP_REQRN)    c = CMD_REQRN;
        else if (p[127 -: OP_LONG_LEN] == OP_READ)     c = CMD_READ;
        else if (p[127 -: OP_LONG_LEN] == OP_WRITE)    c = CMD_WRITE;
        else if (p[127 -: OP_LONG_LEN] == OP_KILL)     c = CMD_KILL;
        return c;
    endfunction

    // Session and RN live at different offsets per opcode; pick the right one here.
    function automatic cmd_fields_t extract_fields(input logic [127:0] p);
        cmd_fields_t f;
        f.cmd  = decode_opcode(p);
        f.q    = p[QUERY_Q_LSB +: 4];
        f.updn = p[QADJ_UPDN_LSB +: 3];
        case (f.cmd)
            CMD_QUERY:    f.session = p[QUERY_SESS_LSB +: 2];
            CMD_QUERYADJ: f.session = p[QADJ_SESS_LSB +: 2];
            default:      f.session = p[QREP_SESS_LSB +: 2];
        endcase
        f.rn = (f.cmd == CMD_REQRN) ? p[REQRN_RN_LSB +: 16] : p[ACK_RN_LSB +: 16];
        return f;
    endfunction

    function automatic logic [14:0] slot_mask(input logic [3:0] q);
        logic [15:0] m;
        m = (16'd1 << q) - 16'd1;
        return m[14:0];
    endfunction

endpackage

// File: rtl/rfid_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for slot,
// RN16 and handle draws.
module rfid_lfsr16
    import rfid_pkg::*;
(
    input  logic        UL_clock,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge UL_clock or negedge reset_n) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[14:0], feedback};
    end

endmodule

// File: rtl/rfid_tag_ctrl.sv
// Tag-side inventory/access FSM: registers decoded uplink commands, then
// updates tag state, slot counter and the backscatter reply request.
module rfid_tag_ctrl
    import rfid_pkg::*;
(
    input  logic         UL_clock,
    input  logic         reset_n,
    input  logic [127:0] packet,
    input  logic         packet_rdy,
    input  logic         tx_ready,
    output logic         tx_valid,
    output logic [2:0]   tx_type,
    output logic [15:0]  tx_data,
    output logic [2:0]   tag_state,
    output logic [14:0]  slot_cnt,
    output logic         cmd_drop
);

    logic [15:0] lfsr;
    logic        rdy_q;
    logic        strobe;
    logic        cmd_pend;
    logic        drop_pend;
    cmd_fields_t cmd_q;
    tag_state_t  state;
    tx_type_t    tx_kind;
    logic [3:0]  q_reg;
    logic [1:0]  session;
    logic [15:0] rn16;
    logic [15:0] handle;
    logic [3:0]  adj_q;
    logic [3:0]  draw_q;
    logic [14:0] draw_slot;
    logic        sess_match;

    rfid_lfsr16 u_lfsr (
        .UL_clock (UL_clock),
        .reset_n  (reset_n),
        .lfsr     (lfsr)
    );

    assign strobe     = packet_rdy && !rdy_q;
    assign sess_match = (cmd_q.session == session);
    assign tag_state  = state;
    assign tx_type    = tx_kind;

    always_comb begin
        adj_q = q_reg;
        if (cmd_q.updn == UPDN_INC && q_reg != 4'd15)
            adj_q = q_reg + 4'd1;
        else if (cmd_q.updn == UPDN_DEC && q_reg != 4'd0)
            adj_q = q_reg - 4'd1;
        draw_q    = (cmd_q.cmd == CMD_QUERY) ? cmd_q.q : adj_q;
        draw_slot = lfsr[14:0] & slot_mask(draw_q);
    end

    always_ff @(posedge UL_clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q     <= 1'b0;
            cmd_pend  <= 1'b0;
            drop_pend <= 1'b0;
            cmd_q     <= '0;
            state     <= ST_READY;
            slot_cnt  <= '0;
            q_reg     <= '0;
            session   <= '0;
            rn16      <= '0;
            handle    <= '0;
            tx_valid  <= 1'b0;
            tx_kind   <= TX_NONE;
            tx_data   <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            rdy_q     <= packet_rdy;
            cmd_pend  <= 1'b0;
            drop_pend <= 1'b0;
            cmd_drop  <= drop_pend;

            // A reply accepted on this same edge does not make the new command busy.
            if (strobe) begin
                cmd_q <= extract_fields(packet);
                if (tx_valid && !tx_ready) drop_pend <= 1'b1;
                else                       cmd_pend  <= 1'b1;
            end

            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
                tx_kind  <= TX_NONE;
                tx_data  <= '0;
            end

            if (cmd_pend) begin
                unique case (cmd_q.cmd)
                    CMD_QUERY, CMD_QUERYADJ: begin
                        if (cmd_q.cmd == CMD_QUERY || sess_match) begin
                            q_reg   <= draw_q;
                            session <= cmd_q.session;
                            if (draw_slot == '0) begin
                                state    <= ST_REPLY;
                                slot_cnt <= '0;
                                rn16     <= lfsr;
                                tx_valid <= 1'b1;
                                tx_kind  <= TX_RN16;
                                tx_data  <= lfsr;
                            end else begin
                                state    <= ST_ARBITRATE;
                                slot_cnt <= draw_slot;
                            end
                        end
                    end
                    CMD_QUERYREP: begin
                        if (sess_match) begin
                            unique case (state)
                                ST_ARBITRATE: begin
                                    if (slot_cnt <= 15'd1) begin
                                        state    <= ST_REPLY;
                                        slot_cnt <= '0;
                                        rn16     <= lfsr;
                                        tx_valid <= 1'b1;
                                        tx_kind  <= TX_RN16;
                                        tx_data  <= lfsr;
                                    end else begin
                                        slot_cnt <= slot_cnt - 15'd1;
                                    end
                                end
                                ST_REPLY: begin
                                    state    <= ST_ARBITRATE;
                                    slot_cnt <= SLOT_PARK;
                                end
                                ST_ACKNOWLEDGED, ST_OPEN: state <= ST_READY;
                                default: ;
                            endcase
                        end
                    end
                    CMD_ACK: begin
                        if (state == ST_REPLY) begin
                            if (cmd_q.rn == rn16) begin
                                state    <= ST_ACKNOWLEDGED;
                                tx_valid <= 1'b1;
                                tx_kind  <= TX_EPC;
                                tx_data  <= '0;
                            end else begin
                                // Parked at the top slot so ARBITRATE never sits at zero.
                                state    <= ST_ARBITRATE;
                                slot_cnt <= SLOT_PARK;
                            end
                        end
                    end
                    CMD_REQRN: begin
                        if (state == ST_ACKNOWLEDGED) begin
                            if (cmd_q.rn == rn16) begin
                                state    <= ST_OPEN;
                                handle   <= lfsr;
                                tx_valid <= 1'b1;
                                tx_kind  <= TX_HANDLE;
                                tx_data  <= lfsr;
                            end else begin
                                state    <= ST_ARBITRATE;
                                slot_cnt <= SLOT_PARK;
                            end
                        end else if (state == ST_OPEN && cmd_q.rn == handle) begin
                            rn16     <= lfsr;
                            tx_valid <= 1'b1;
                            tx_kind  <= TX_RN16;
                            tx_data  <= lfsr;
                        end
                    end
                    CMD_READ, CMD_WRITE, CMD_KILL: begin
                        if (state == ST_OPEN) begin
                            tx_valid <= 1'b1;
                            tx_kind  <= TX_ERROR;
                            tx_data  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rfid_tag_ctrl.sv
// Self-checking bench for rfid_tag_ctrl: directed scenarios plus randomized
// command traffic compared every cycle against a behavioural tag model.
module tb_rfid_tag_ctrl;

    logic         UL_clock   = 1'b0;
    logic         reset_n    = 1'b0;
    logic [127:0] packet     = '0;
    logic         packet_rdy = 1'b0;
    logic         tx_ready   = 1'b0;
    logic         tx_valid;
    logic [2:0]   tx_type;
    logic [15:0]  tx_data;
    logic [2:0]   tag_state;
    logic [14:0]  slot_cnt;
    logic         cmd_drop;

    int errors = 0;
    int checks = 0;

    localparam int S_READY = 0, S_ARB = 1, S_REPLY = 2, S_ACKD = 3, S_OPEN = 4;
    localparam int T_NONE = 0, T_RN16 = 1, T_EPC = 2, T_HANDLE = 3, T_ERROR = 4;

    rfid_tag_ctrl dut (
        .UL_clock   (UL_clock),
        .reset_n    (reset_n),
        .packet     (packet),
        .packet_rdy (packet_rdy),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_type    (tx_type),
        .tx_data    (tx_data),
        .tag_state  (tag_state),
        .slot_cnt   (slot_cnt),
        .cmd_drop   (cmd_drop)
    );

    always #5 UL_clock = ~UL_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state, m_slot, m_q, m_sess, m_type;
    logic [15:0] m_rn, m_handle, m_lfsr, m_data;
    bit          m_valid, m_drop, m_prev, m_has, m_busy;
    logic [128:0] m_pend[$];
    logic [128:0] m_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_reset();
        m_state = S_READY; m_slot = 0; m_q = 0; m_sess = 0;
        m_rn = '0; m_handle = '0; m_lfsr = 16'hACE1;
        m_valid = 0; m_type = T_NONE; m_data = '0; m_drop = 0; m_prev = 0;
        m_pend.delete();
    endtask

    task automatic model_reply(input int t, input logic [15:0] d);
        m_valid = 1; m_type = t; m_data = d;
    endtask

    task automatic model_enter_reply();
        m_state = S_REPLY; m_slot = 0; m_rn = m_lfsr;
        model_reply(T_RN16, m_lfsr);
    endtask

    task automatic model_cmd(input logic [127:0] p);
        logic [7:0] op;
        op = p[127:120];
        if (op[7:6] == 2'b00) begin
            if (int'(p[125:124]) != m_sess) return;
            if (m_state == S_ARB) begin
                m_slot = m_slot - 1;
                if (m_slot == 0) model_enter_reply();
            end else if (m_state == S_REPLY) begin
                m_state = S_ARB; m_slot = 32767;
            end else if (m_state == S_ACKD || m_state == S_OPEN) begin
                m_state = S_READY;
            end
        end else if (op[7:6] == 2'b01) begin
            if (m_state != S_REPLY) return;
            if (p[125:110] == m_rn) begin
                m_state = S_ACKD; model_reply(T_EPC, 16'h0);
            end else begin
                m_state = S_ARB; m_slot = 32767;
            end
        end else if (op[7:4] == 4'h8 || op[7:4] == 4'h9) begin
            if (op[7:4] == 4'h8) begin
                m_q = int'(p[114:111]); m_sess = int'(p[117:116]);
            end else begin
                if (int'(p[123:122]) != m_sess) return;
                if (p[121:119] == 3'b110 && m_q < 15) m_q = m_q + 1;
                else if (p[121:119] == 3'b011 && m_q > 0) m_q = m_q - 1;
            end
            m_slot = int'(m_lfsr) % (1 << m_q);
            if (m_slot == 0) model_enter_reply();
            else m_state = S_ARB;
        end else if (op == 8'hC1) begin
            if (m_state == S_ACKD) begin
                if (p[119:104] == m_rn) begin
                    m_state = S_OPEN; m_handle = m_lfsr; model_reply(T_HANDLE, m_lfsr);
                end else begin
                    m_state = S_ARB; m_slot = 32767;
                end
            end else if (m_state == S_OPEN && p[119:104] == m_handle) begin
                m_rn = m_lfsr; model_reply(T_RN16, m_lfsr);
            end
        end else if (op >= 8'hC2 && op <= 8'hC4) begin
            if (m_state == S_OPEN) model_reply(T_ERROR, 16'h0);
        end
    endtask

    always @(posedge UL_clock or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_drop = 0;
            m_busy = m_valid && !tx_ready;
            m_has  = (m_pend.size() > 0);
            if (m_has) m_e = m_pend.pop_front();
            if (m_valid && tx_ready) begin
                m_valid = 0; m_type = T_NONE; m_data = '0;
            end
            if (m_has) begin
                if (m_e[128]) m_drop = 1;
                else model_cmd(m_e[127:0]);
            end
            if (packet_rdy && !m_prev) m_pend.push_back({m_busy, packet});
            m_prev = packet_rdy;
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge UL_clock) begin
        chk("cyc_tx_valid", 32'(tx_valid), 32'(m_valid));
        chk("cyc_tx_type", 32'(tx_type), 32'(m_type));
        chk("cyc_tx_data", 32'(tx_data), 32'(m_data));
        chk("cyc_tag_state", 32'(tag_state), 32'(m_state));
        chk("cyc_slot_cnt", 32'(slot_cnt), 32'(m_slot));
        chk("cyc_cmd_drop", 32'(cmd_drop), 32'(m_drop));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] pk_query(input int q, input int s);
        logic [127:0] p;
        p = rnd128();
        p[127:124] = 4'b1000; p[117:116] = s[1:0]; p[114:111] = q[3:0];
        return p;
    endfunction

    function automatic logic [127:0] pk_qrep(input int s);
        logic [127:0] p;
        p = rnd128();
        p[127:126] = 2'b00; p[125:124] = s[1:0];
        return p;
    endfunction

    function automatic logic [127:0] pk_qadj(input int s, input logic [2:0] updn);
        logic [127:0] p;
        p = rnd128();
        p[127:124] = 4'b1001; p[123:122] = s[1:0]; p[121:119] = updn;
        return p;
    endfunction

    function automatic logic [127:0] pk_ack(input logic [15:0] rn);
        logic [127:0] p;
        p = rnd128();
        p[127:126] = 2'b01; p[125:110] = rn;
        return p;
    endfunction

    function automatic logic [127:0] pk_reqrn(input logic [15:0] rn);
        logic [127:0] p;
        p = rnd128();
        p[127:120] = 8'hC1; p[119:104] = rn;
        return p;
    endfunction

    function automatic logic [127:0] pk_op8(input logic [7:0] op);
        logic [127:0] p;
        p = rnd128();
        p[127:120] = op;
        return p;
    endfunction

    // Returns at the negedge after edge k+1, with packet_rdy dropped.
    task automatic send(input logic [127:0] p);
        @(negedge UL_clock);
        packet = p; packet_rdy = 1'b1;
        @(negedge UL_clock);
        @(negedge UL_clock);
        packet_rdy = 1'b0;
    endtask

    task automatic accept();
        @(negedge UL_clock); tx_ready = 1'b1;
        @(negedge UL_clock); tx_ready = 1'b0;
    endtask

    // Waits until a strobe raised at the next negedge draws with an LFSR value
    // whose low bits satisfy the requested condition.
    task automatic wait_draw(input bit want_low3_five, input string name);
        logic [15:0] la;
        bit found;
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge UL_clock);
            la = lfsr_step(lfsr_step(m_lfsr));
            if (want_low3_five) found = (la[2:0] == 3'd5);
            else                found = (la[14:0] != 15'd0);
        end
        if (!found) begin
            errors++; checks++;
            $display("FAIL %s: lfsr lookahead not found, got none, expected match", name);
        end
    endtask

    function automatic logic [127:0] rand_cmd();
        int r, s;
        logic [15:0] rn;
        r = $urandom_range(0, 9);
        s = ($urandom_range(0, 9) < 8) ? m_sess : int'($urandom_range(0, 3));
        case (r)
            0, 1: return pk_query(int'($urandom_range(0, 2)), s);
            2, 3, 9: return pk_qrep(s);
            4: return pk_qadj(s, ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b011);
            5: begin
                rn = ($urandom_range(0, 3) != 0) ? m_rn : 16'($urandom);
                return pk_ack(rn);
            end
            6: begin
                case ($urandom_range(0, 2))
                    0: rn = m_rn;
                    1: rn = m_handle;
                    default: rn = 16'($urandom);
                endcase
                return pk_reqrn(rn);
            end
            7: return pk_op8(8'hC2 + 8'($urandom_range(0, 2)));
            default: return pk_op8(($urandom_range(0, 1) == 1) ? 8'hC5 : 8'hA7);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] saved;
    int w, g;

    initial begin
        model_reset();
        @(negedge UL_clock);
        @(negedge UL_clock);
        chk("reset_state", 32'(tag_state), 32'(S_READY));
        chk("reset_slot", 32'(slot_cnt), 32'd0);
        chk("reset_valid", 32'(tx_valid), 32'd0);
        chk("reset_type", 32'(tx_type), 32'd0);
        chk("reset_data", 32'(tx_data), 32'd0);
        chk("reset_drop", 32'(cmd_drop), 32'd0);

        // Query Q=0 raised right at reset release: draw uses the first LFSR step 16'h59C3.
        reset_n = 1'b1;
        packet = pk_query(0, 1); packet_rdy = 1'b1;
        @(negedge UL_clock);
        @(negedge UL_clock);
        packet_rdy = 1'b0;
        chk("q0_state", 32'(tag_state), 32'(S_REPLY));
        chk("q0_valid", 32'(tx_valid), 32'd1);
        chk("q0_type", 32'(tx_type), 32'(T_RN16));
        chk("q0_data", 32'(tx_data), 32'h59C3);
        repeat (5) @(negedge UL_clock);
        chk("q0_hold_valid", 32'(tx_valid), 32'd1);
        chk("q0_hold_data", 32'(tx_data), 32'h59C3);

        accept();
        send(pk_ack(16'h59C3));
        chk("ack_state", 32'(tag_state), 32'(S_ACKD));
        chk("ack_type", 32'(tx_type), 32'(T_EPC));
        chk("ack_data", 32'(tx_data), 32'd0);
        accept();
        send(pk_reqrn(16'h59C3));
        chk("reqrn_state", 32'(tag_state), 32'(S_OPEN));
        chk("reqrn_type", 32'(tx_type), 32'(T_HANDLE));
        accept();
        send(pk_op8(8'hC2));
        chk("read_type", 32'(tx_type), 32'(T_ERROR));
        chk("read_state", 32'(tag_state), 32'(S_OPEN));
        accept();

        // Busy: second command while the reply is still pending is dropped.
        send(pk_query(0, 2));
        saved = m_data;
        send(pk_query(0, 2));
        chk("busy_drop", 32'(cmd_drop), 32'd1);
        chk("busy_state", 32'(tag_state), 32'(S_REPLY));
        chk("busy_data", 32'(tx_data), 32'(saved));
        @(negedge UL_clock);
        chk("busy_drop_clear", 32'(cmd_drop), 32'd0);

        // Asynchronous reset while a reply is pending.
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", 32'(tx_valid), 32'd0);
        chk("areset_type", 32'(tx_type), 32'd0);
        chk("areset_data", 32'(tx_data), 32'd0);
        chk("areset_state", 32'(tag_state), 32'd0);
        chk("areset_slot", 32'(slot_cnt), 32'd0);
        @(negedge UL_clock);
        reset_n = 1'b1;

        // Slotted arbitration: Q=3 with slot 5.
        wait_draw(1'b1, "slot5_lookahead");
        send(pk_query(3, 0));
        chk("slot5_state", 32'(tag_state), 32'(S_ARB));
        chk("slot5_slot", 32'(slot_cnt), 32'd5);
        repeat (4) send(pk_qrep(0));
        chk("slot1_slot", 32'(slot_cnt), 32'd1);
        chk("slot1_state", 32'(tag_state), 32'(S_ARB));
        chk("slot1_valid", 32'(tx_valid), 32'd0);
        send(pk_qrep(0));
        chk("slot0_state", 32'(tag_state), 32'(S_REPLY));
        chk("slot0_type", 32'(tx_type), 32'(T_RN16));
        accept();

        // RN mismatch and session filtering.
        send(pk_ack(m_rn ^ 16'h0001));
        chk("ackbad_state", 32'(tag_state), 32'(S_ARB));
        chk("ackbad_valid", 32'(tx_valid), 32'd0);
        saved = 16'(m_slot);
        send(pk_qrep(3));
        chk("sessbad_state", 32'(tag_state), 32'(S_ARB));
        chk("sessbad_slot", 32'(slot_cnt), 32'(saved));

        // QueryAdjust saturation at both ends.
        wait_draw(1'b0, "q15_lookahead");
        send(pk_query(15, 0));
        chk("q15_state", 32'(tag_state), 32'(S_ARB));
        wait_draw(1'b0, "q15up_lookahead");
        send(pk_qadj(0, 3'b110));
        chk("q15up_state", 32'(tag_state), 32'(S_ARB));
        send(pk_query(0, 0));
        accept();
        send(pk_qadj(0, 3'b011));
        chk("q0dn_state", 32'(tag_state), 32'(S_REPLY));
        chk("q0dn_type", 32'(tx_type), 32'(T_RN16));
        chk("q0dn_slot", 32'(slot_cnt), 32'd0);
        accept();

        // Randomized traffic with random tx_ready back-pressure.
        for (int it = 0; it < 400; it++) begin
            @(negedge UL_clock);
            packet = rand_cmd(); packet_rdy = 1'b1;
            tx_ready = 1'($urandom_range(0, 1));
            w = int'($urandom_range(1, 3));
            repeat (w) begin
                @(negedge UL_clock);
                tx_ready = 1'($urandom_range(0, 1));
            end
            packet_rdy = 1'b0;
            g = int'($urandom_range(1, 3));
            repeat (g) begin
                @(negedge UL_clock);
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
        tx_ready = 1'b0;
        repeat (3) @(negedge UL_clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
